noise_arbiter: RTL and testbench
================================

NOISE_ARBITER -- requirements
Module: noise_arbiter

Interface
REQ-001 Parameter EXPLO_DIV, default 48, explosion noise-clock period in clk_3MHz_en ticks (2..255).
REQ-002 Parameter SHELL_DIV, default 12, shell noise-clock period in clk_3MHz_en ticks (2..255).
REQ-003 Parameter HOLD_TICKS, default 1024, grant hold time in clk_3MHz_en ticks (1..65535).
REQ-004 clk  in  1  system clock; the only clock in the block.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 clk_3MHz_en  in  1  one-clk-wide 3 MHz tick enable.
REQ-007 explo_req  in  1  explosion trigger level; a rising edge requests.
REQ-008 explo_loud  in  1  explosion loudness (1 = loud), sampled at grant.
REQ-009 shell_req  in  1  shell trigger level; a rising edge requests.
REQ-010 shell_loud  in  1  shell loudness (1 = loud), sampled at grant.
REQ-011 noise_en  out  1  held high while a source owns the noise generator.
REQ-012 loud_soft  out  1  loudness of the current or last owner.
REQ-013 noise_clk_en  out  1  one-clk pulse that clocks the noise flip-flop.
REQ-014 owner  out  2  00 idle, 01 explosion, 10 shell; 11 is never driven.

Function
REQ-015 Edge detection SHALL use one registered copy per request input; the edge is req & ~req_q, evaluated every clk and not gated by clk_3MHz_en.
REQ-016 The state machine SHALL have three states, IDLE, EXPLO and SHELL; owner SHALL equal the state encoding.
REQ-017 IDLE -> EXPLO on an explosion edge; IDLE -> SHELL on a shell edge; if both edges occur in the same cycle, EXPLO wins.
REQ-018 SHELL -> EXPLO on an explosion edge (preemption); the shell grant SHALL be discarded, not queued.
REQ-019 In EXPLO, a shell edge SHALL be ignored and dropped.
REQ-020 On a same-source edge while that source owns the generator (retrigger), the state SHALL be unchanged, the hold counter reloaded and loudness resampled.
REQ-021 On every grant (entry, preemption or retrigger), the 16-bit hold counter SHALL load HOLD_TICKS and loud_soft SHALL load that source's loud input, both in the edge cycle.
REQ-022 In EXPLO or SHELL, the hold counter SHALL decrement by 1 on each clk_3MHz_en.
- When the counter would reach 0, the state SHALL go to IDLE in that same cycle.
- A grant in the same cycle overrides the decrement and expiry.
REQ-023 noise_en SHALL be registered and equal (state != IDLE); it rises one clk after the edge cycle.
REQ-024 loud_soft SHALL hold its value in IDLE.
REQ-025 An 8-bit divider counter SHALL advance on each clk_3MHz_en.
- When it equals DIV-1, noise_clk_en SHALL pulse in that cycle and the counter SHALL wrap to 0.
- DIV is SHELL_DIV in SHELL and EXPLO_DIV in EXPLO and IDLE.
- noise_clk_en is never high without clk_3MHz_en.
REQ-026 The divider counter SHALL clear to 0 in any cycle where the state changes between different values, or on a retrigger.
REQ-027 noise_clk_en SHALL keep running in IDLE so the downstream noise decays with a live source.
REQ-028 No arithmetic SHALL wrap: the hold counter never decrements below 0 and the divider never exceeds DIV-1.

Reset
REQ-029 While reset is high, the following SHALL be cleared: state IDLE, owner 00, noise_en 0, loud_soft 0, noise_clk_en 0, hold and divider counters 0, edge registers 0.
REQ-030 On the first clk after reset deasserts, edge registers SHALL load current inputs, so a level already high does not count as an edge.
REQ-031 Reset asserted mid-grant SHALL abort the grant with no pending request retained.

Verification (HOLD_TICKS=8, EXPLO_DIV=4, SHELL_DIV=2, clk_3MHz_en every 4th clk)
REQ-032 Scenario: shell_req rises with shell_loud=1 -> owner=10 next clk, noise_en=1, loud_soft=1; noise_clk_en every 8 clks; IDLE after 8 ticks; noise_clk_en continues every 16 clks.
REQ-033 Scenario: explo_req and shell_req rise in the same clk -> owner=01, loud_soft=explo_loud, shell edge lost.
REQ-034 Scenario: explosion edge at tick 3 of a shell grant -> owner 10->01, divider cleared, next noise_clk_en 16 clks later, hold restarts at 8.
REQ-035 Scenario: shell edge during EXPLO -> no change to owner, hold or loud_soft.
REQ-036 Scenario: explosion retrigger at tick 6 with explo_loud 1->0 -> owner stays 01, loud_soft=0, IDLE 8 ticks after the retrigger.
REQ-037 Scenario: reset pulse during a grant while explo_req is held high -> all outputs 0 and no grant after release until a new rising edge.

Source files
------------

// File: rtl/noise_arbiter.sv
// Arbitrates the explosion and shell sources for one shared noise generator.
// It also divides the 3 MHz tick down to the noise flip-flop clock enable.
module noise_arbiter #(
    parameter int EXPLO_DIV  = 48,
    parameter int SHELL_DIV  = 12,
    parameter int HOLD_TICKS = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_3MHz_en,
    input  logic       explo_req,
    input  logic       explo_loud,
    input  logic       shell_req,
    input  logic       shell_loud,
    output logic       noise_en,
    output logic       loud_soft,
    output logic       noise_clk_en,
    output logic [1:0] owner
);

    // state | meaning
    // IDLE  | no owner; divider free-runs at the explosion rate
    // EXPLO | explosion owns the generator; shell edges are dropped
    // SHELL | shell owns the generator; an explosion edge preempts it
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXPLO = 2'b01,
        SHELL = 2'b10
    } state_t;

    localparam logic [7:0]  EXPLO_LIM = 8'(EXPLO_DIV - 1);
    localparam logic [7:0]  SHELL_LIM = 8'(SHELL_DIV - 1);
    localparam logic [15:0] HOLD_INIT = 16'(HOLD_TICKS);

    state_t      state;
    state_t      state_next;
    logic        explo_q;
    logic        shell_q;
    logic        armed;
    logic        explo_edge;
    logic        shell_edge;
    logic        grant_explo;
    logic        grant_shell;
    logic        retrig;
    logic        expire;
    logic        div_clr;
    logic        div_wrap;
    logic [7:0]  div_lim;
    logic [7:0]  div;
    logic [15:0] hold;

    // armed stays low for the first clk after reset so a level already high is not an edge
    assign explo_edge  = armed & explo_req & ~explo_q;
    assign shell_edge  = armed & shell_req & ~shell_q;
    assign grant_explo = explo_edge;
    assign grant_shell = shell_edge & ~explo_edge & (state != EXPLO);
    assign retrig      = (grant_explo & (state == EXPLO)) | (grant_shell & (state == SHELL));
    assign expire      = (state != IDLE) & clk_3MHz_en & (hold <= 16'd1);
    assign div_lim     = (state == SHELL) ? SHELL_LIM : EXPLO_LIM;
    assign div_wrap    = (div >= div_lim);
    assign div_clr     = (state_next != state) | retrig;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            noise_en <= 1'b0;
        end else begin
            state    <= state_next;
            noise_en <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state;
        if (grant_explo) begin
            state_next = EXPLO;
        end else if (grant_shell) begin
            state_next = SHELL;
        end else if (expire) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        owner        = state;
        noise_clk_en = ~reset & clk_3MHz_en & div_wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            explo_q   <= 1'b0;
            shell_q   <= 1'b0;
            armed     <= 1'b0;
            hold      <= 16'd0;
            div       <= 8'd0;
            loud_soft <= 1'b0;
        end else begin
            explo_q <= explo_req;
            shell_q <= shell_req;
            armed   <= 1'b1;

            if (grant_explo || grant_shell) begin
                hold <= HOLD_INIT;
            end else if ((state != IDLE) && clk_3MHz_en && (hold != 16'd0)) begin
                hold <= hold - 16'd1;
            end

            if (grant_explo) begin
                loud_soft <= explo_loud;
            end else if (grant_shell) begin
                loud_soft <= shell_loud;
            end

            if (div_clr) begin
                div <= 8'd0;
            end else if (clk_3MHz_en) begin
                div <= div_wrap ? 8'd0 : div + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_noise_arbiter.sv
// Directed bench for noise_arbiter with HOLD_TICKS=8, EXPLO_DIV=4, SHELL_DIV=2,
// and a tick on every 4th clk.
module tb_noise_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_3MHz_en;
    logic       explo_req;
    logic       explo_loud;
    logic       shell_req;
    logic       shell_loud;
    logic       noise_en;
    logic       loud_soft;
    logic       noise_clk_en;
    logic [1:0] owner;

    int vectors     = 0;
    int miscompares = 0;
    int phase       = 0;
    int tick_seen   = 0;
    int nce_seen    = 0;
    int pulses      = 0;

    noise_arbiter #(
        .EXPLO_DIV (4),
        .SHELL_DIV (2),
        .HOLD_TICKS(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_3MHz_en (clk_3MHz_en),
        .explo_req   (explo_req),
        .explo_loud  (explo_loud),
        .shell_req   (shell_req),
        .shell_loud  (shell_loud),
        .noise_en    (noise_en),
        .loud_soft   (loud_soft),
        .noise_clk_en(noise_clk_en),
        .owner       (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clk: drive the tick for this cycle, sample noise_clk_en mid-cycle, pass the edge.
    task automatic clk1();
        clk_3MHz_en = (phase == 3);
        phase       = (phase + 1) % 4;
        #1;
        tick_seen = int'(clk_3MHz_en);
        nce_seen  = int'(noise_clk_en);
        @(posedge clk);
        #1;
    endtask

    // Ticks consumed until owner returns to idle; -1 if it never does.
    task automatic ticks_to_idle(output int t);
        int n;
        t = 0;
        n = 0;
        pulses = 0;
        while (owner !== 2'b00 && n < 200) begin
            clk1();
            t += tick_seen;
            pulses += nce_seen;
            n++;
        end
        if (owner !== 2'b00) t = -1;
    endtask

    // Clks until the next noise_clk_en pulse (inclusive); -1 on timeout.
    task automatic clks_to_nce(output int c);
        c = 0;
        for (int i = 1; i <= 100; i++) begin
            clk1();
            if (nce_seen != 0) begin
                c = i;
                break;
            end
        end
        if (c == 0) c = -1;
    endtask

    task automatic run_ticks(input int want);
        int t;
        int n;
        t = 0;
        n = 0;
        while (t < want && n < 100) begin
            clk1();
            t += tick_seen;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        int c;
        int any;

        reset = 1'b1; clk_3MHz_en = 1'b0;
        explo_req = 1'b0; explo_loud = 1'b0; shell_req = 1'b0; shell_loud = 1'b0;
        @(posedge clk); #1;

        any = 0;
        repeat (4) begin clk1(); any |= nce_seen; end
        chk("rst_owner", owner, 0);
        chk("rst_noise_en", noise_en, 0);
        chk("rst_loud", loud_soft, 0);
        chk("rst_nce", any, 0);
        reset = 1'b0;
        clk1();

        // shell grant, hold expiry, idle divider
        shell_loud = 1'b1; shell_req = 1'b1;
        clk1();
        chk("s1_owner", owner, 2);
        chk("s1_noise_en", noise_en, 1);
        chk("s1_loud", loud_soft, 1);
        ticks_to_idle(t);
        chk("s1_hold_ticks", t, 8);
        chk("s1_shell_pulses", pulses, 4);
        chk("s1_noise_en_off", noise_en, 0);
        chk("s1_loud_held", loud_soft, 1);
        clks_to_nce(c);
        chk("s1_idle_nce_a", c, 16);
        clks_to_nce(c);
        chk("s1_idle_nce_b", c, 16);
        shell_req = 1'b0;
        clk1();

        // simultaneous edges: explosion wins, shell lost
        explo_loud = 1'b0; shell_loud = 1'b1;
        explo_req = 1'b1; shell_req = 1'b1;
        clk1();
        chk("s2_owner", owner, 1);
        chk("s2_loud", loud_soft, 0);
        ticks_to_idle(t);
        chk("s2_hold_ticks", t, 8);
        any = 0;
        repeat (8) begin clk1(); any |= int'(owner); end
        chk("s2_shell_lost", any, 0);
        explo_req = 1'b0; shell_req = 1'b0;
        clk1();

        // explosion preempts shell on the third tick
        shell_loud = 1'b0; shell_req = 1'b1;
        clk1();
        chk("s3_shell_owner", owner, 2);
        run_ticks(2);
        while (phase != 3) clk1();
        explo_loud = 1'b1; explo_req = 1'b1;
        clk1();
        chk("s3_preempt_owner", owner, 1);
        chk("s3_preempt_loud", loud_soft, 1);
        clks_to_nce(c);
        chk("s3_first_nce", c, 16);
        chk("s3_owner_mid", owner, 1);
        ticks_to_idle(t);
        chk("s3_hold_rest", t, 4);
        explo_req = 1'b0; shell_req = 1'b0;
        clk1();

        // shell edge during explosion is ignored
        explo_loud = 1'b1; explo_req = 1'b1;
        clk1();
        chk("s4_owner", owner, 1);
        t = 0;
        while (t < 2) begin clk1(); t += tick_seen; end
        shell_loud = 1'b0; shell_req = 1'b1;
        clk1();
        t += tick_seen;
        chk("s4_ignored_owner", owner, 1);
        chk("s4_ignored_loud", loud_soft, 1);
        ticks_to_idle(c);
        chk("s4_hold_total", t + c, 8);
        explo_req = 1'b0; shell_req = 1'b0;
        clk1();

        // explosion retrigger with loudness change
        explo_loud = 1'b1; explo_req = 1'b1;
        clk1();
        explo_req = 1'b0;
        run_ticks(6);
        chk("s5_owner_pre", owner, 1);
        explo_loud = 1'b0; explo_req = 1'b1;
        clk1();
        chk("s5_retrig_owner", owner, 1);
        chk("s5_retrig_loud", loud_soft, 0);
        ticks_to_idle(t);
        chk("s5_hold_after", t, 8);
        chk("s5_loud_held", loud_soft, 0);
        explo_req = 1'b0;
        clk1();

        // reset mid-grant with request held high
        explo_loud = 1'b1; explo_req = 1'b1;
        clk1();
        chk("s6_owner", owner, 1);
        clk1(); clk1();
        reset = 1'b1;
        any = 0;
        repeat (4) begin clk1(); any |= nce_seen; end
        chk("s6_rst_owner", owner, 0);
        chk("s6_rst_noise_en", noise_en, 0);
        chk("s6_rst_loud", loud_soft, 0);
        chk("s6_rst_nce", any, 0);
        reset = 1'b0;
        any = 0;
        repeat (20) begin clk1(); any |= int'(owner); end
        chk("s6_no_grant", any, 0);
        explo_req = 1'b0;
        clk1();
        explo_req = 1'b1;
        clk1();
        chk("s6_new_edge", owner, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
